// File: rtl/mfcc_frame_controller.sv
// MFCC frame controller: selects a coefficient window from each DCT frame,
// forwards it through a one-entry output register, marks group boundaries
// (per utterance when enrolling, per frame when verifying), counts frames and
// flags framing errors. Control FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
module mfcc_frame_controller #(
    parameter int NUM_COEFFS  = 26,
    parameter int FIRST_COEFF = 2,
    parameter int LAST_COEFF  = 13,
    parameter int NUM_FRAMES  = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [1:0]                    mode_in,
    input  logic                          start_in,
    input  logic [31:0]                   coeff_data_in,
    input  logic                          coeff_valid_in,
    input  logic                          coeff_last_in,
    output logic                          coeff_ready_out,
    output logic [31:0]                   feature_data_out,
    output logic                          feature_valid_out,
    output logic                          feature_last_out,
    input  logic                          feature_ready_in,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out
);

    localparam int FRAME_W = $clog2(NUM_FRAMES);
    // One spare bit so a frame missing its last beat saturates instead of wrapping
    localparam int IDX_W   = $clog2(NUM_COEFFS) + 1;

    localparam logic [IDX_W-1:0]   IDX_FIRST   = IDX_W'(FIRST_COEFF);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(LAST_COEFF);
    localparam logic [IDX_W-1:0]   IDX_END     = IDX_W'(NUM_COEFFS - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX     = {IDX_W{1'b1}};
    localparam logic [FRAME_W-1:0] FRAME_FINAL = FRAME_W'(NUM_FRAMES - 1);

    localparam logic [1:0] MODE_ENROLL = 2'b01;
    localparam logic [1:0] MODE_VERIFY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;

    logic                 verify_r;
    logic [IDX_W-1:0]     idx_r;
    logic [FRAME_W-1:0]   frame_r;
    logic                 error_r;

    logic                 out_valid_r;
    logic                 out_last_r;
    logic [31:0]          out_data_r;
    logic [FRAME_W-1:0]   out_frame_r;

    logic                 ready_s;
    logic                 busy_s;
    logic                 done_s;

    logic                 start_ok_s;
    logic                 kept_s;
    logic                 out_free_s;
    logic                 run_hs_s;
    logic                 keep_hs_s;
    logic                 final_hs_s;
    logic                 out_hs_s;
    logic                 frame_error_s;
    logic                 beat_last_s;

    assign start_ok_s    = start_in && ((mode_in == MODE_ENROLL) || (mode_in == MODE_VERIFY));
    assign kept_s        = (idx_r >= IDX_FIRST) && (idx_r <= IDX_LAST);
    // The output register can take a new beat if empty or being consumed now
    assign out_free_s    = !out_valid_r || feature_ready_in;
    assign run_hs_s      = (state_r == ST_RUN) && coeff_valid_in && ready_s;
    assign keep_hs_s     = run_hs_s && kept_s;
    assign final_hs_s    = run_hs_s && coeff_last_in && (frame_r == FRAME_FINAL);
    assign out_hs_s      = out_valid_r && feature_ready_in;
    // A last flag must coincide exactly with the final coefficient position
    assign frame_error_s = run_hs_s && (coeff_last_in != (idx_r == IDX_END));
    assign beat_last_s   = (idx_r == IDX_LAST) && (verify_r || (frame_r == FRAME_FINAL));

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (final_hs_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_free_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Per-state outputs: input ready, busy and completion pulse
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
            end
            ST_RUN: begin
                busy_s  = 1'b1;
                ready_s = kept_s ? out_free_s : 1'b1;
            end
            ST_DRAIN: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Utterance bookkeeping: mode, coefficient index, frame count, sticky error
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            verify_r <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            frame_r  <= {FRAME_W{1'b0}};
            error_r  <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_ok_s) begin
            verify_r <= (mode_in == MODE_VERIFY);
            idx_r    <= {IDX_W{1'b0}};
            frame_r  <= {FRAME_W{1'b0}};
            error_r  <= 1'b0;
        end else if (run_hs_s) begin
            if (coeff_last_in) begin
                idx_r <= {IDX_W{1'b0}};
                if (frame_r != FRAME_FINAL) begin
                    frame_r <= frame_r + {{(FRAME_W-1){1'b0}}, 1'b1};
                end
            end else if (idx_r != IDX_MAX) begin
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (frame_error_s) begin
                error_r <= 1'b1;
            end
        end
    end

    // One-entry output register; a reload on a simultaneous drain keeps it full
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 32'd0;
            out_frame_r <= {FRAME_W{1'b0}};
        end else if (keep_hs_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= beat_last_s;
            out_data_r  <= coeff_data_in;
            out_frame_r <= frame_r;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign coeff_ready_out   = ready_s;
    assign busy_out          = busy_s;
    assign done_out          = done_s;
    assign error_out         = error_r;
    assign feature_valid_out = out_valid_r;
    assign feature_last_out  = out_last_r;
    assign feature_data_out  = out_data_r;
    assign frame_idx_out     = out_frame_r;

endmodule

// File: doc/mfcc_frame_controller.md
MFCC_FRAME_CONTROLLER -- requirements
Module: mfcc_frame_controller

Interface
REQ-001 Parameter NUM_COEFFS, default 26, DCT coefficients per frame on the input stream.
REQ-002 Parameter FIRST_COEFF, default 2, lowest coefficient index forwarded.
REQ-003 Parameter LAST_COEFF, default 13, highest coefficient index forwarded.
REQ-004 Parameter NUM_FRAMES, default 32, frames per utterance.
REQ-005 Port clk_in, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst_in, input, 1, reset, asynchronous assert, active-low.
REQ-007 Port mode_in, input, 2, 01 enroll, 10 verify, 00 and 11 idle; sampled only on start_in.
REQ-008 Port start_in, input, 1, single-cycle request to begin an utterance.
REQ-009 Port coeff_data_in, input, 32, DCT coefficient.
REQ-010 Port coeff_valid_in / coeff_last_in, input, 1 each, beat valid / last beat of frame.
REQ-011 Port coeff_ready_out, output, 1, input handshake ready.
REQ-012 Port feature_data_out, output, 32, forwarded coefficient.
REQ-013 Port feature_valid_out / feature_last_out, output, 1 each, beat valid / last beat of group.
REQ-014 Port feature_ready_in, input, 1, downstream ready.
REQ-015 Port frame_idx_out, output, $clog2(NUM_FRAMES), frame number of current output beat.
REQ-016 Port busy_out, done_out, error_out, output, 1 each: not IDLE; one-cycle completion pulse; sticky framing error.

Function
REQ-017 States IDLE, RUN, DRAIN, DONE; handshake occurs when valid and ready both high in the same cycle.
REQ-018 IDLE: coeff_ready_out=1, input beats discarded; start_in with mode 01/10 latches mode, clears counters and error_out, goes RUN next cycle; start_in with mode 00/11 ignored.
REQ-019 start_in outside IDLE ignored; mode_in changes outside IDLE ignored.
REQ-020 RUN: coefficient index counter increments per input handshake, returns to 0 after a handshake with coeff_last_in=1.
REQ-021 Beats with index in [FIRST_COEFF, LAST_COEFF] are kept; all others are dropped with coeff_ready_out=1.
REQ-022 For a kept beat, coeff_ready_out = !feature_valid_out || feature_ready_in (one-entry output register, full throughput, no combinational path from coeff_valid_in to outputs).
REQ-023 Kept beat accepted in cycle N appears on feature_data_out with feature_valid_out=1 in cycle N+1; data, last and frame_idx_out held stable until handshake.
REQ-024 Enroll: feature_last_out=1 only on the LAST_COEFF beat of frame NUM_FRAMES-1.
REQ-025 Verify: feature_last_out=1 on the LAST_COEFF beat of every frame.
REQ-026 Frame counter increments on each coeff_last_in handshake; on handshake of last beat of frame NUM_FRAMES-1, go DRAIN and deassert coeff_ready_out.
REQ-027 DRAIN: coeff_ready_out=0; when output register empty (or emptying this cycle), go DONE.
REQ-028 DONE: done_out=1 for exactly one cycle, coeff_ready_out=0, next state IDLE.
REQ-029 Framing error: coeff_last_in=1 at index != NUM_COEFFS-1, or coeff_last_in=0 at index NUM_COEFFS-1 -> error_out set; index resyncs to 0 on the next last beat; the frame still counts.
REQ-030 error_out remains set until reset or accepted start_in.
REQ-031 Simultaneous input and output handshakes in the same cycle: output register reloads with the new beat, feature_valid_out stays 1.
REQ-032 Frame counter width exactly $clog2(NUM_FRAMES); no wrap reached within an utterance.

Reset
REQ-033 On rst_in low, immediately: state IDLE, counters 0, feature_valid_out=0, feature_last_out=0, feature_data_out=0, frame_idx_out=0, done_out=0, error_out=0, busy_out=0, coeff_ready_out=1 once released into IDLE.
REQ-034 Reset mid-utterance discards any pending output beat and emits no done_out.

Verification (NUM_FRAMES=4, other defaults)
REQ-035 Enroll, 4 frames of 26 beats, data=index, feature_ready_in=1 -> 48 output beats, data 2..13 repeated, feature_last_out only on beat 48, done_out one cycle after drain, error_out=0.
REQ-036 Verify, same stimulus -> feature_last_out on beats 12,24,36,48, frame_idx_out 0..3.
REQ-037 Enroll with feature_ready_in toggling 1/0 each cycle -> same 48 beats in order, no loss or duplicate, coeff_ready_out low whenever the output register is full and unconsumed.
REQ-038 Frame 1 with coeff_last_in at index 20 -> error_out=1 from the next cycle, frame counted, subsequent frames forwarded normally, done_out after frame 3.
REQ-039 start_in with mode_in=11 -> stays IDLE; start_in during RUN -> ignored; rst_in low mid-frame 2 -> all outputs at reset values in the same cycle, no done_out.
